// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Frame FSM states, default frame width and line idle level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int   DEF_DATA_W = 8;
  localparam logic TX_IDLE    = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request scanning up from ptr_i, wrapping.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N_REQ   = 4,
  localparam int OWNER_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic               any_o,
  output logic [N_REQ-1:0]   win_o,
  output logic [OWNER_W-1:0] idx_o
);

  int   j;
  logic hit;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = OWNER_W'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one serial TX line among N_REQ byte requesters, round robin.
// One clk_bps cycle per bit period; all outputs are registered.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int STOP_BITS = 1,
  localparam int OWNER_W   = $clog2(N_REQ)
) (
  input  logic                    clk_bps,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic [OWNER_W-1:0]      owner,
  output logic                    busy,
  output logic                    done,
  output logic                    tx,
  output logic                    act_led
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SC_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  tx_state_e          state_q, state_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [SC_W-1:0]    scnt_q, scnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tx_q, tx_d;
  logic               led_q, led_d;

  logic               win_any;
  logic [N_REQ-1:0]   win_oh;
  logic [OWNER_W-1:0] win_idx;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (win_any),
    .win_o (win_oh),
    .idx_o (win_idx)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    owner_d = owner_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    led_d   = led_q;
    unique case (state_q)
      IDLE: begin
        if (en && win_any) begin
          gnt_d   = win_oh;
          shreg_d = data[int'(win_idx)*DATA_W +: DATA_W];
          owner_d = win_idx;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
          ptr_d   = (win_idx == OWNER_W'(N_REQ - 1)) ?
                    '0 : win_idx + OWNER_W'(1);
        end
      end
      START: begin
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        bcnt_d  = '0;
        state_d = DATA;
      end
      DATA: begin
        if (bcnt_q == BC_W'(DATA_W - 1)) begin
          tx_d    = TX_IDLE;
          scnt_d  = '0;
          state_d = STOP;
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bcnt_d  = bcnt_q + BC_W'(1);
        end
      end
      STOP: begin
        if (scnt_q == SC_W'(STOP_BITS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          led_d   = ~led_q;
        end else begin
          scnt_d = scnt_q + SC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n is active-high here: 1 holds the block in reset
  always_ff @(posedge clk_bps or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= TX_IDLE;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      led_q   <= led_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tx      = tx_q;
  assign act_led = led_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: 1-stop and 2-stop instances.
// Stimulus queues expected grants/frames; negedge monitors pop and compare.
module tb_uart_tx_scheduler;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy, done, tx, act_led;

  logic        en2;
  logic [3:0]  req2;
  logic [31:0] data2;
  logic [3:0]  gnt2;
  logic [1:0]  owner2;
  logic        busy2, done2, tx2, led2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gnt_cnt  = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  exp_t        expq[$];
  logic [10:0] exp2[$];
  int          gcyc[$];

  logic [3:0] rearm;
  logic [3:0] pend;

  uart_tx_scheduler #(
    .N_REQ(4), .DATA_W(8), .STOP_BITS(1)
  ) dut (
    .clk_bps(clk), .rst_n(rst_n), .en(en), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .busy(busy), .done(done), .tx(tx),
    .act_led(act_led)
  );

  uart_tx_scheduler #(
    .N_REQ(4), .DATA_W(8), .STOP_BITS(2)
  ) dut2 (
    .clk_bps(clk), .rst_n(rst_n), .en(en2), .req(req2), .data(data2),
    .gnt(gnt2), .owner(owner2), .busy(busy2), .done(done2), .tx(tx2),
    .act_led(led2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, want, $time);
    end
  endtask

  // Monitor for the 1-stop-bit instance
  bit         in_fr = 0;
  int         pos   = 0;
  logic [7:0] cur;
  logic       led_exp = 1'b0;
  logic       exp_tx;
  exp_t       e;

  always @(negedge clk) begin
    if (rst_n) begin
      in_fr   = 0;
      led_exp = 1'b0;
    end else begin
      if (gnt != 4'b0) begin
        gnt_cnt++;
        gcyc.push_back(cyc);
        if (in_fr || expq.size() == 0) begin
          chk("gnt_unexpected", {28'b0, gnt}, 32'h0);
        end else begin
          e = expq.pop_front();
          chk("gnt_onehot", {28'b0, gnt}, 32'(1) << e.idx);
          chk("owner", {30'b0, owner}, e.idx);
          cur   = e.b;
          in_fr = 1;
          pos   = 0;
        end
      end
      if (in_fr) begin
        if (pos < 10) begin
          exp_tx = (pos == 0) ? 1'b0 : (pos <= 8) ? cur[pos-1] : 1'b1;
          chk($sformatf("tx_bit%0d", pos), {31'b0, tx}, {31'b0, exp_tx});
          chk("busy_in_frame", {31'b0, busy}, 1);
          chk("done_early", {31'b0, done}, 0);
          pos++;
        end else begin
          chk("done_pulse", {31'b0, done}, 1);
          chk("busy_end", {31'b0, busy}, 0);
          chk("tx_end", {31'b0, tx}, 1);
          led_exp = ~led_exp;
          chk("act_led", {31'b0, act_led}, {31'b0, led_exp});
          done_cnt++;
          in_fr = 0;
        end
      end else if (gnt == 4'b0) begin
        if (done !== 1'b0) chk("done_stray", {31'b0, done}, 0);
        if (tx !== 1'b1) chk("tx_idle", {31'b0, tx}, 1);
      end
    end
  end

  // Requester model: drop after gnt, optionally re-assert one cycle later
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        req[i]  = 1'b1;
        pend[i] = 1'b0;
      end
      if (gnt[i]) begin
        req[i] = 1'b0;
        if (rearm[i]) begin
          pend[i]  = 1'b1;
          rearm[i] = 1'b0;
        end
      end
    end
  end

  // Monitor for the 2-stop-bit instance
  bit          in2 = 0;
  int          p2  = 0;
  logic [10:0] f2;

  always @(negedge clk) begin
    if (rst_n) begin
      in2 = 0;
    end else begin
      if (gnt2 != 4'b0) begin
        req2 = req2 & ~gnt2;
        if (in2 || exp2.size() == 0) begin
          chk("gnt2_unexpected", {28'b0, gnt2}, 32'h0);
        end else begin
          f2  = exp2.pop_front();
          in2 = 1;
          p2  = 0;
        end
      end
      if (in2) begin
        if (p2 < 11) begin
          chk($sformatf("tx2_bit%0d", p2), {31'b0, tx2}, {31'b0, f2[p2]});
          chk("done2_early", {31'b0, done2}, 0);
          p2++;
        end else begin
          chk("done2_pulse", {31'b0, done2}, 1);
          chk("busy2_end", {31'b0, busy2}, 0);
          done2_cnt++;
          in2 = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_gnt", {28'b0, gnt}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_led", {31'b0, act_led}, 0);
    chk("rst_owner", {30'b0, owner}, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
  endtask

  task automatic wait_done(input int which, input int n);
    int s;
    int k;
    s = (which == 1) ? done_cnt : done2_cnt;
    k = 0;
    while (((which == 1) ? done_cnt : done2_cnt) == s && k < n) begin
      tick(1);
      k++;
    end
    chk($sformatf("done%0d_seen", which),
        {31'b0, ((which == 1) ? done_cnt : done2_cnt) != s}, 1);
  endtask

  task automatic wait_gnt(input int n);
    int s;
    int k;
    s = gnt_cnt;
    k = 0;
    while (gnt_cnt == s && k < n) begin
      tick(1);
      k++;
    end
    chk("gnt_seen", {31'b0, gnt_cnt != s}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b0;
    data  = 32'h0;
    en2   = 1'b1;
    req2  = 4'b0;
    data2 = 32'h0;
    rearm = 4'b0;
    pend  = 4'b0;
    #1;
    do_reset();

    // Single request: 0xA5 from requester 1
    data = 32'h0000_A500;
    expq.push_back('{1, 8'hA5});
    req = 4'b0010;
    wait_done(1, 20);
    chk("led_after_single", {31'b0, act_led}, 1);

    // Round robin from a fresh pointer, all requesters active
    do_reset();
    data = 32'h4433_2211;
    gcyc.delete();
    expq.push_back('{0, 8'h11});
    expq.push_back('{1, 8'h22});
    expq.push_back('{2, 8'h33});
    expq.push_back('{3, 8'h44});
    expq.push_back('{0, 8'h11});
    rearm = 4'b0001;
    req   = 4'b1111;
    repeat (5) wait_done(1, 30);
    chk("rr_grant_count", gcyc.size(), 5);
    if (gcyc.size() == 5) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("rr_gap%0d", k), gcyc[k+1] - gcyc[k], 11);
    end

    // en gating, then en dropped mid-frame
    en   = 1'b0;
    data = 32'h3C00_0000;
    req  = 4'b1000;
    n    = gnt_cnt;
    tick(20);
    chk("en_blocks", gnt_cnt, n);
    expq.push_back('{3, 8'h3C});
    en = 1'b1;
    c  = cyc;
    wait_gnt(5);
    chk("en_grant_edge", gcyc[$], c + 1);
    tick(3);
    en = 1'b0;
    wait_done(1, 20);
    chk("busy_after_en_frame", {31'b0, busy}, 0);
    en = 1'b1;

    // Grant 2, abort with reset, then pointer must restart at 0
    data = 32'hC35A_0000;
    expq.push_back('{2, 8'h5A});
    req = 4'b0100;
    wait_gnt(5);
    tick(3);
    n = done_cnt;
    do_reset();
    tick(15);
    chk("abort_no_done", done_cnt, n);
    expq.push_back('{2, 8'h5A});
    expq.push_back('{3, 8'hC3});
    req = 4'b1100;
    wait_done(1, 20);
    wait_done(1, 20);

    // Two stop bits: 0x00 then 0x81
    exp2.push_back(11'b11_0000_0000_0);
    data2 = 32'h0000_8100;
    req2  = 4'b0001;
    wait_done(2, 20);
    exp2.push_back({2'b11, 8'h81, 1'b0});
    req2 = 4'b0010;
    wait_done(2, 20);

    tick(2);
    chk("expq_drained", expq.size(), 0);
    chk("exp2_drained", exp2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
